// File: rtl/ip_s_axis_mm2s_rd.sv
// Single-burst MM2S read path.
// Accepts one read request, issues one DataMover MM2S command, and forwards
// the returned stream to the user IP through a single registered
// valid/ready stage. It pulses done once the last beat has drained, and
// raises a sticky error if TLAST and the expected burst length disagree.
module ip_s_axis_mm2s_rd #(
  parameter int ADDR_WIDTH           = 32,
  parameter int READ_BURST_LEN       = 8,
  parameter int C_S_AXIS_TDATA_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            uip2axi_rd_en,
  input  logic [ADDR_WIDTH-1:0]           uip2axi_rd_addr,
  output logic                            axi2uip_rd_busy,
  output logic                            m_axis_mm2s_cmd_tvalid,
  input  logic                            m_axis_mm2s_cmd_tready,
  output logic [ADDR_WIDTH+39:0]          m_axis_mm2s_cmd_tdata,
  input  logic                            s_axis_mm2s_tvalid,
  output logic                            s_axis_mm2s_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_mm2s_tdata,
  input  logic                            s_axis_mm2s_tlast,
  output logic                            axi2uip_rd_valid,
  input  logic                            axi2uip_rd_ready,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] axi2uip_rd_data,
  output logic                            axi2uip_rd_done,
  output logic                            axi2uip_rd_err
);

  localparam int BTT   = READ_BURST_LEN * (C_S_AXIS_TDATA_WIDTH / 8);
  localparam int CNT_W = $clog2(READ_BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [22:0]      BTT_FLD  = 23'(BTT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                          state_reg;
  logic [CNT_W-1:0]                cnt_reg;
  logic [ADDR_WIDTH+39:0]          cmd_reg;
  logic                            rd_valid_reg;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_data_reg;
  logic                            done_reg;
  logic                            err_reg;

  logic beat_acc;
  logic last_cnt;
  logic burst_end;
  logic drain_ok;

  // Input is accepted only in DATA, and only when the output register can take it.
  assign s_axis_mm2s_tready = (state_reg == DATA) && (!rd_valid_reg || axi2uip_rd_ready);
  assign beat_acc           = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
  assign last_cnt           = (cnt_reg == LAST_CNT);
  assign burst_end          = beat_acc && (last_cnt || s_axis_mm2s_tlast);
  assign drain_ok           = !rd_valid_reg || axi2uip_rd_ready;

  assign axi2uip_rd_busy        = (state_reg != IDLE);
  assign m_axis_mm2s_cmd_tvalid = (state_reg == CMD);
  assign m_axis_mm2s_cmd_tdata  = cmd_reg;
  assign axi2uip_rd_valid       = rd_valid_reg;
  assign axi2uip_rd_data        = rd_data_reg;
  assign axi2uip_rd_done        = done_reg;
  assign axi2uip_rd_err         = err_reg;

  // Control FSM: command capture, beat counting, end-of-burst and error detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cmd_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The done cycle still belongs to the previous burst, so a
          // request arriving alongside the done pulse is dropped.
          if (uip2axi_rd_en && !done_reg) begin
            cmd_reg   <= {4'h0, 4'hB, uip2axi_rd_addr, 1'b0, 1'b1, 6'h00, 1'b1, BTT_FLD};
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= CMD;
          end
        end
        CMD: begin
          if (m_axis_mm2s_cmd_tready) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (beat_acc) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (burst_end) begin
              state_reg <= DONE;
              if (last_cnt != s_axis_mm2s_tlast) begin
                err_reg <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (drain_ok) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output register: load on an accepted beat, otherwise clear once consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else if (beat_acc) begin
      rd_valid_reg <= 1'b1;
      rd_data_reg  <= s_axis_mm2s_tdata;
    end else if (axi2uip_rd_ready) begin
      rd_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ip_s_axis_mm2s_rd.sv
// Directed bench for ip_s_axis_mm2s_rd (default parameters: 32-bit address,
// 8-beat bursts, 128-bit data). Inputs are driven on the falling edge and
// outputs are sampled on the falling edge.
module tb_ip_s_axis_mm2s_rd;

  logic         clk;
  logic         rstn;
  logic         rd_en;
  logic [31:0]  rd_addr;
  logic         busy;
  logic         cmd_tvalid;
  logic         cmd_tready;
  logic [71:0]  cmd_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] s_tdata;
  logic         s_tlast;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] rd_data;
  logic         rd_done;
  logic         rd_err;

  int n_cmp  = 0;
  int n_fail = 0;

  ip_s_axis_mm2s_rd #(
    .ADDR_WIDTH(32),
    .READ_BURST_LEN(8),
    .C_S_AXIS_TDATA_WIDTH(128)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .uip2axi_rd_en(rd_en),
    .uip2axi_rd_addr(rd_addr),
    .axi2uip_rd_busy(busy),
    .m_axis_mm2s_cmd_tvalid(cmd_tvalid),
    .m_axis_mm2s_cmd_tready(cmd_tready),
    .m_axis_mm2s_cmd_tdata(cmd_tdata),
    .s_axis_mm2s_tvalid(s_tvalid),
    .s_axis_mm2s_tready(s_tready),
    .s_axis_mm2s_tdata(s_tdata),
    .s_axis_mm2s_tlast(s_tlast),
    .axi2uip_rd_valid(rd_valid),
    .axi2uip_rd_ready(rd_ready),
    .axi2uip_rd_data(rd_data),
    .axi2uip_rd_done(rd_done),
    .axi2uip_rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int seed, input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(seed * 256 + i);
    return {w, ~w, w + 32'd1, w ^ 32'h5A5A_5A5A};
  endfunction

  // Command word expected for an 8 x 16-byte burst (BTT = 128, tag 0xB, EOF, INCR).
  function automatic logic [71:0] exp_cmd(input logic [31:0] addr);
    return {4'h0, 4'hB, addr, 1'b0, 1'b1, 6'h00, 1'b1, 23'd128};
  endfunction

  // One complete request: issue, command handshake after cmd_wait stall cycles,
  // source beats 0..nsrc-1 (tlast on beat tlast_at), collect and check outputs.
  task automatic do_burst(input logic [31:0] addr, input int seed, input int nsrc,
                          input int tlast_at, input int cmd_wait, input bit toggle_rdy,
                          input int exp_beats, input bit exp_err, input int exp_cyc,
                          input bit busy_pulse);
    int  src_i;
    int  out_n;
    int  cyc;
    bit  done_seen;
    src_i = 0; out_n = 0; cyc = 0; done_seen = 0;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0; rd_addr = 32'hDEAD_BEEF;
    chk("cmd_tvalid", 128'(cmd_tvalid), 128'd1);
    chk("cmd_tdata", 128'(cmd_tdata), 128'(exp_cmd(addr)));
    chk("err_cleared", 128'(rd_err), 128'd0);
    chk("busy", 128'(busy), 128'd1);
    s_tvalid = 1'b1; s_tdata = pat(seed, 0); s_tlast = (tlast_at == 0);
    for (int k = 0; k < cmd_wait; k++) begin
      #1;
      chk("cmdwait_s_tready", 128'(s_tready), 128'd0);
      @(negedge clk);
      chk("cmdwait_tvalid", 128'(cmd_tvalid), 128'd1);
      chk("cmdwait_tdata", 128'(cmd_tdata), 128'(exp_cmd(addr)));
    end
    cmd_tready = 1'b1;
    #1;
    chk("hs_s_tready", 128'(s_tready), 128'd0);
    @(negedge clk);
    cmd_tready = 1'b0;
    chk("cmd_dropped", 128'(cmd_tvalid), 128'd0);
    while (!done_seen && cyc < 200) begin
      if (rd_done) begin
        done_seen = 1'b1;
        chk("done_err", 128'(rd_err), 128'(exp_err));
        chk("done_beats_out", 128'(out_n), 128'(exp_beats));
        chk("done_beats_in", 128'(src_i), 128'(exp_beats));
        if (exp_cyc >= 0) chk("done_latency", 128'(cyc), 128'(exp_cyc));
        rd_en = busy_pulse;
      end else begin
        rd_en    = busy_pulse && (cyc == 2);
        rd_ready = toggle_rdy ? cyc[0] : 1'b1;
        s_tvalid = (src_i < nsrc);
        s_tdata  = pat(seed, src_i);
        s_tlast  = (src_i == tlast_at);
        #1;
        if (rd_valid && !rd_ready) chk("bp_s_tready", 128'(s_tready), 128'd0);
        if (rd_valid && rd_ready) begin
          chk("beat_data", rd_data, pat(seed, out_n));
          out_n++;
        end
        if (s_tvalid && s_tready) src_i++;
        cyc++;
        @(negedge clk);
      end
    end
    chk("done_timeout", 128'(done_seen), 128'd1);
    s_tvalid = 1'b0; s_tlast = 1'b0; rd_ready = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("done_pulse_width", 128'(rd_done), 128'd0);
    chk("no_extra_cmd", 128'(cmd_tvalid), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("err_sticky", 128'(rd_err), 128'(exp_err));
    $display("burst seed=%0d addr=%h beats=%0d err=%0d cycles=%0d", seed, addr, out_n, rd_err, cyc);
  endtask

  initial begin
    int src_i;
    rstn = 1'b0; rd_en = 1'b0; rd_addr = '0; cmd_tready = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_cmd_tvalid", 128'(cmd_tvalid), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("rst_done_err", {126'd0, rd_done, rd_err}, 128'd0);
    rstn = 1'b1;

    // Basic burst: minimum latency, 11 cycles request-to-done.
    do_burst(32'h1000_0040, 1, 8, 7, 0, 1'b0, 8, 1'b0, 9, 1'b0);
    // Command backpressure for 5 cycles.
    do_burst(32'h2000_0100, 2, 8, 7, 5, 1'b0, 8, 1'b0, -1, 1'b0);
    // Output backpressure: rd_ready toggles every cycle.
    do_burst(32'h3000_0000, 3, 8, 7, 0, 1'b1, 8, 1'b0, -1, 1'b0);
    // Early TLAST on beat 5: ends after 6 beats with error.
    do_burst(32'h4000_0080, 4, 8, 5, 0, 1'b0, 6, 1'b1, -1, 1'b0);
    // Missing TLAST: ends after 8 beats with error, extra beats refused.
    do_burst(32'h5000_0000, 5, 10, -1, 0, 1'b0, 8, 1'b1, -1, 1'b0);
    // Correct burst clears the sticky error.
    do_burst(32'h6000_0040, 6, 8, 7, 0, 1'b0, 8, 1'b0, -1, 1'b0);

    // Asynchronous reset while beat 3 is in flight.
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 32'h7000_0000;
    @(negedge clk);
    rd_en = 1'b0; cmd_tready = 1'b1;
    @(negedge clk);
    cmd_tready = 1'b0;
    src_i = 0;
    for (int c = 0; c < 20 && src_i < 3; c++) begin
      s_tvalid = 1'b1; s_tdata = pat(7, src_i); s_tlast = 1'b0;
      #1;
      if (s_tready) src_i++;
      if (src_i < 3) @(negedge clk);
    end
    chk("pre_rst_beats", 128'(src_i), 128'd3);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_cmd", {55'd0, cmd_tvalid, cmd_tdata}, 128'd0);
    chk("arst_s_tready", 128'(s_tready), 128'd0);
    chk("arst_rd_valid", 128'(rd_valid), 128'd0);
    chk("arst_rd_data", rd_data, 128'd0);
    chk("arst_done_err", {126'd0, rd_done, rd_err}, 128'd0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_no_replay", {126'd0, cmd_tvalid, rd_valid}, 128'd0);
    $display("reset mid-burst after %0d beats", src_i);

    // Clean burst after reset, with rd_en pulsed mid-burst and on the done cycle.
    do_burst(32'h8000_0040, 8, 8, 7, 0, 1'b0, 8, 1'b0, 9, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
